// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider arbiter.
package div_arb_pkg;

    // Scheduler states; FLUSH is the post-reset quiet period.
    typedef enum logic [2:0] {
        ST_FLUSH = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // Width of a requester index; never below one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Quotient returned for a bypassed divide-by-zero (sliced to WIDTH).
    localparam logic [63:0] QUOT_ALL_ONES = '1;

endpackage

// File: rtl/div_rr_pick.sv
// Combinational round-robin picker: first valid request at or after rr_ptr,
// searching upward and wrapping modulo N_REQ (works for non-power-of-2 N_REQ).
module div_rr_pick
    import div_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IW-1:0]    rr_ptr,
    output logic [N_REQ-1:0] grant_oh,
    output logic [IW-1:0]    grant_idx,
    output logic             any
);

    logic [IW:0]   cand_w;
    logic [IW-1:0] cand;

    // Walk the candidates in priority order and keep the first valid one.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand_w    = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_w = {1'b0, rr_ptr} + (IW+1)'(i);
            if (cand_w >= (IW+1)'(N_REQ)) begin
                cand_w = cand_w - (IW+1)'(N_REQ);
            end
            cand = cand_w[IW-1:0];
            if (!any && req_valid[cand]) begin
                any            = 1'b1;
                grant_idx      = cand;
                grant_oh[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin scheduler sharing one start/done divider among N_REQ requesters.
// Optional build macro: DIV_ZERO_BYPASS_EN -- a divisor of zero is answered
// directly (quotient all ones, remainder = dividend) without starting the divider.
// Request handshake: req_ready is one-hot and only asserted in IDLE; a request is
// taken when req_valid[i] && req_ready[i] at a rising edge. Response handshake:
// rsp_* are held stable while rsp_valid is high and retire on rsp_valid && rsp_ready.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter  int N_REQ        = 4,
    parameter  int WIDTH        = 8,
    parameter  int FLUSH_CYCLES = 2*WIDTH+4,
    localparam int IW           = id_width(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_dividend,
    input  logic [N_REQ*WIDTH-1:0] req_divisor,
    output logic                   div_start,
    output logic [WIDTH-1:0]       div_dividend,
    output logic [WIDTH-1:0]       div_divisor,
    input  logic                   div_done,
    input  logic [WIDTH-1:0]       div_quotient,
    input  logic [WIDTH-1:0]       div_remainder,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IW-1:0]          rsp_id,
    output logic [WIDTH-1:0]       rsp_quotient,
    output logic [WIDTH-1:0]       rsp_remainder,
    output state_t                 dbg_state
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t            state_q, state_d;
    logic [CW-1:0]     flush_cnt_q, flush_cnt_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]  dividend_q, dividend_d;
    logic [WIDTH-1:0]  divisor_q, divisor_d;
    logic [IW-1:0]     id_q, id_d;
    logic [WIDTH-1:0]  quot_q, quot_d;
    logic [WIDTH-1:0]  rem_q, rem_d;

    logic [N_REQ-1:0]  pick_oh;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic [WIDTH-1:0]  sel_dividend;
    logic [WIDTH-1:0]  sel_divisor;

    div_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // Select the operands of the requester the picker chose.
    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IW'(i)) begin
                sel_dividend = req_dividend[i*WIDTH +: WIDTH];
                sel_divisor  = req_divisor[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state logic; div_done only matters in WAIT.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        id_d        = id_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        case (state_q)
            ST_FLUSH: begin
                flush_cnt_d = flush_cnt_q + CW'(1);
                if (flush_cnt_q == CW'(FLUSH_CYCLES-1)) begin
                    flush_cnt_d = '0;
                    state_d     = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (pick_any) begin
                    dividend_d = sel_dividend;
                    divisor_d  = sel_divisor;
                    id_d       = pick_idx;
                    rr_ptr_d   = (pick_idx == IW'(N_REQ-1)) ? '0 : pick_idx + IW'(1);
`ifdef DIV_ZERO_BYPASS_EN
                    if (sel_divisor == '0) begin
                        quot_d  = QUOT_ALL_ONES[WIDTH-1:0];
                        rem_d   = sel_dividend;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
`else
                    state_d = ST_ISSUE;
`endif
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (div_done) begin
                    quot_d  = div_quotient;
                    rem_d   = div_remainder;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_FLUSH;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FLUSH;
            flush_cnt_q <= '0;
            rr_ptr_q    <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            id_q        <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            id_q        <= id_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
        end
    end

    assign req_ready     = (state_q == ST_IDLE) ? pick_oh : '0;
    assign div_start     = (state_q == ST_ISSUE);
    assign div_dividend  = dividend_q;
    assign div_divisor   = divisor_q;
    assign rsp_valid     = (state_q == ST_RESP);
    assign rsp_id        = id_q;
    assign rsp_quotient  = quot_q;
    assign rsp_remainder = rem_q;
    assign dbg_state     = state_q;

endmodule
